down_timer_ctrl: RTL
====================

# down_timer_ctrl

Programmable countdown-timer controller that sequences a loadable down counter. It accepts a configuration (load value, prescale, one-shot/periodic mode) over a valid/ready handshake. It runs, pauses, resumes and aborts the count on command, and issues a one-cycle terminal-count pulse. It sits between the register/control logic and the counter datapath, and is the single owner of the counter's load and decrement enables.

## Interface
Parameters:
- WIDTH, 4, counter width in bits
- PW, 4, prescaler width in bits

Ports:
- clk  in  1  clock; all logic on rising edge
- clr_n  in  1  reset, asynchronous, active-low
- cfg_valid  in  1  config request
- cfg_ready  out  1  config accepted when high; high in IDLE and DONE
- cfg_load  in  WIDTH  count start value L
- cfg_pre  in  PW  prescale value P; one count tick every P+1 clocks
- cfg_reload  in  1  1 = periodic, 0 = one-shot
- start  in  1  start or resume counting
- stop  in  1  pause counting
- abort  in  1  cancel and return to IDLE
- cnt  out  WIDTH  current count value (registered)
- tc  out  1  terminal-count pulse, one cycle (registered)
- busy  out  1  high in RUN and PAUSE
- done  out  1  high in DONE (one-shot finished)

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Config transfer occurs when cfg_valid && cfg_ready (IDLE or DONE only).
  - Latches L, P and the reload mode into internal registers.
  - Sets cnt <= L.
  - From DONE, moves to IDLE.
- Command priority in one cycle: abort > stop > start > config.
- IDLE, start:
  - Moves to RUN.
  - Sets cnt <= L_reg and prescaler <= P_reg.
- RUN:
  - The prescaler decrements every clock.
  - A tick occurs when the prescaler is 0; the prescaler then reloads P_reg.
  - On a tick with cnt != 0: cnt <= cnt - 1.
  - On a tick with cnt == 0: tc <= 1 for the next cycle.
    - Periodic mode: cnt <= L_reg and stay in RUN.
    - One-shot mode: go to DONE, and cnt holds 0.
- RUN, stop:
  - Moves to PAUSE.
  - No tick and no decrement that cycle, even if the prescaler is 0.
  - Prescaler and cnt freeze.
- PAUSE, start:
  - Moves to RUN.
  - Prescaler and cnt resume from their frozen values; there is no reload.
- DONE, start:
  - Moves to RUN.
  - Sets cnt <= L_reg and prescaler <= P_reg.
- abort in any state:
  - Moves to IDLE.
  - Sets cnt <= L_reg.
  - tc is not asserted that cycle or the next, even if a tick coincided.
- Ignored commands: stop outside RUN, and start in RUN.
- Arithmetic is unsigned modulo 2^WIDTH. cnt never wraps below 0 under controller control.
- L = 0 is legal: tc fires on the first tick.
- Reset: clr_n low forces, asynchronously:
  - state IDLE
  - cnt 0; L_reg, P_reg and mode 0; prescaler 0
  - tc 0, busy 0, done 0
  - cfg_ready 1

## Timing
- Start sampled in cycle N: RUN from cycle N+1, with cnt = L visible in N+1.
- First tick at the end of cycle N+1+P.
- One-shot run duration: (L+1)*(P+1) clocks in RUN.
  - tc is high in cycle N+1+(L+1)(P+1).
  - done and DONE begin in the same cycle as tc.
- Periodic mode: tc repeats every (L+1)*(P+1) clocks, with no dead cycle.
- cfg_ready, busy and done are decoded from the state register (no extra latency).
- A config accepted in cycle N is reflected on cnt in N+1.
- Reset released mid-count gives a full restart from IDLE; there is no partial state.

## Structure
- Shared package down_timer_pkg:
  - state enum (IDLE, RUN, PAUSE, DONE)
  - default WIDTH/PW constants
- Sub-module down_cnt_ld:
  - loadable down counter with ports clk, clr_n, ld, ld_val, en, q, zero
  - instantiated once for cnt
- The prescaler, FSM, config registers and tc register live in down_timer_ctrl.

## Test plan
- L=3, P=0, one-shot, start at cycle 0:
  - cnt = 3,2,1,0 in cycles 1–4
  - tc = 1 in cycle 5 only
  - done = 1 from cycle 5, busy = 0
- L=2, P=1, periodic:
  - tc pulses every 6 clocks for at least 3 periods
  - cnt reloads to 2 with no gap
- L=5, P=0, stop at cnt=3 held for 4 cycles, then start:
  - cnt stays 3 while paused, then continues 2,1,0
  - tc is exactly 4 run-cycles after the stop point
- abort coincident with the terminal tick (L=1, P=0):
  - no tc
  - state IDLE, cnt = 1
- cfg_valid during RUN:
  - cfg_ready = 0 and the config is not taken
  - the same config in DONE is accepted, and the next cycle shows IDLE with cnt = new L
- clr_n low mid-RUN with cnt=2:
  - all outputs go to reset values immediately (asynchronous)
  - after release, start gives cnt = 0 and tc on the first tick

Source files
------------

// File: rtl/down_timer_pkg.sv
// Shared types and default sizes for the down_timer_ctrl block.
package down_timer_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_PW    = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/down_cnt_ld.sv
// Loadable down counter; load wins over decrement and the count never wraps below zero.
import down_timer_pkg::*;

module down_cnt_ld #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic             zero
);

  logic [WIDTH-1:0] q_d, q_q;

  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = ld_val;
    end else if (en && (q_q != '0)) begin
      q_d = q_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign zero = (q_q == '0);

endmodule

// File: rtl/down_timer_ctrl.sv
// Countdown-timer sequencer: owns config registers, prescaler, FSM and the
// load/decrement enables of the count register.
//
//   state    | meaning
//   ST_IDLE  | configured or aborted, waiting for start/config
//   ST_RUN   | prescaler running, count ticks down
//   ST_PAUSE | prescaler and count frozen, waiting for start
//   ST_DONE  | one-shot expired, count held at zero
import down_timer_pkg::*;

module down_timer_ctrl #(
  parameter int WIDTH = DEF_WIDTH,
  parameter int PW    = DEF_PW
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_load,
  input  logic [PW-1:0]    cfg_pre,
  input  logic             cfg_reload,
  input  logic             start,
  input  logic             stop,
  input  logic             abort,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_e           state_d, state_q;
  logic [WIDTH-1:0] load_d, load_q;
  logic [PW-1:0]    pre_val_d, pre_val_q;
  logic             reload_d, reload_q;
  logic [PW-1:0]    pre_d, pre_q;
  logic             tc_d, tc_q;

  logic             cnt_ld;
  logic [WIDTH-1:0] cnt_ld_val;
  logic             cnt_en;
  logic             cnt_zero;

  always_comb begin
    state_d    = state_q;
    load_d     = load_q;
    pre_val_d  = pre_val_q;
    reload_d   = reload_q;
    pre_d      = pre_q;
    tc_d       = 1'b0;
    cnt_ld     = 1'b0;
    cnt_ld_val = load_q;
    cnt_en     = 1'b0;

    if (abort) begin
      // abort suppresses any coincident terminal tick
      state_d = ST_IDLE;
      cnt_ld  = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d = ST_RUN;
            cnt_ld  = 1'b1;
            pre_d   = pre_val_q;
          end else if (cfg_valid) begin
            state_d    = ST_IDLE;
            load_d     = cfg_load;
            pre_val_d  = cfg_pre;
            reload_d   = cfg_reload;
            cnt_ld     = 1'b1;
            cnt_ld_val = cfg_load;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_PAUSE;
          end else if (pre_q == '0) begin
            pre_d = pre_val_q;
            if (!cnt_zero) begin
              cnt_en = 1'b1;
            end else begin
              tc_d = 1'b1;
              if (reload_q) begin
                cnt_ld = 1'b1;
              end else begin
                state_d = ST_DONE;
              end
            end
          end else begin
            pre_d = pre_q - 1'b1;
          end
        end
        ST_PAUSE: begin
          if (start) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= ST_IDLE;
      load_q    <= '0;
      pre_val_q <= '0;
      reload_q  <= 1'b0;
      pre_q     <= '0;
      tc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      load_q    <= load_d;
      pre_val_q <= pre_val_d;
      reload_q  <= reload_d;
      pre_q     <= pre_d;
      tc_q      <= tc_d;
    end
  end

  down_cnt_ld #(.WIDTH(WIDTH)) u_cnt (
    .clk    (clk),
    .clr_n  (clr_n),
    .ld     (cnt_ld),
    .ld_val (cnt_ld_val),
    .en     (cnt_en),
    .q      (cnt),
    .zero   (cnt_zero)
  );

  assign tc        = tc_q;
  assign cfg_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign done      = (state_q == ST_DONE);

endmodule
